dm_bus_bridge: RTL



---
 rtl/rvcpu_mem_pkg.sv | 50 +++++
 rtl/dm_lane_align.sv | 48 ++++
 rtl/dm_bus_bridge.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/rvcpu_mem_pkg.sv
// Shared data-memory encodings: load/store control codes,
// access sizes and the bus bridge FSM states.
package rvcpu_mem_pkg;

  typedef enum logic [2:0] {
    RD_NONE = 3'b000,
    RD_LB   = 3'b001,
    RD_LBU  = 3'b010,
    RD_LH   = 3'b011,
    RD_LHU  = 3'b100,
    RD_LW   = 3'b101,
    RD_LWU  = 3'b110,
    RD_LD   = 3'b111
  } rd_ctrl_e;

  typedef enum logic [2:0] {
    WR_NONE = 3'b000,
    WR_SB   = 3'b001,
    WR_SH   = 3'b010,
    WR_SW   = 3'b011,
    WR_SD   = 3'b100
  } wr_ctrl_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_D
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_e;

  function automatic logic [7:0] size_mask(size_e s);
    logic [7:0] m;
    m = 8'h01;
    case (s)
      SZ_B: m = 8'h01;
      SZ_H: m = 8'h03;
      SZ_W: m = 8'h0f;
      SZ_D: m = 8'hff;
      default: m = 8'h01;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane alignment for a 64-bit data bus: misalignment
// detect, store lane shift/strobes, load extract/extend.
module dm_lane_align
  import rvcpu_mem_pkg::*;
(
  input  logic [2:0]  off_i,
  input  size_e       size_i,
  input  logic [63:0] din_i,
  output logic        misalign_o,
  output logic [7:0]  wstrb_o,
  output logic [63:0] wdata_o,
  input  logic [2:0]  ld_off_i,
  input  size_e       ld_size_i,
  input  logic        ld_sgn_i,
  input  logic [63:0] rdata_i,
  output logic [63:0] ld_data_o
);

  logic [63:0] sh;

  always_comb begin
    misalign_o = 1'b0;
    case (size_i)
      SZ_B: misalign_o = 1'b0;
      SZ_H: misalign_o = off_i[0];
      SZ_W: misalign_o = |off_i[1:0];
      SZ_D: misalign_o = |off_i;
      default: misalign_o = 1'b0;
    endcase
  end

  assign wstrb_o = size_mask(size_i) << off_i;
  assign wdata_o = din_i << {off_i, 3'b000};

  assign sh = rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    ld_data_o = sh;
    case (ld_size_i)
      SZ_B: ld_data_o = {{56{ld_sgn_i & sh[7]}}, sh[7:0]};
      SZ_H: ld_data_o = {{48{ld_sgn_i & sh[15]}}, sh[15:0]};
      SZ_W: ld_data_o = {{32{ld_sgn_i & sh[31]}}, sh[31:0]};
      SZ_D: ld_data_o = sh;
      default: ld_data_o = sh;
    endcase
  end

endmodule

// File: rtl/dm_bus_bridge.sv
// MEM-stage to 64-bit req/ack bus bridge with pipeline stall.
// Define DM_BUS_BRIDGE_TIMEOUT_EN to enable the ack watchdog.
module dm_bus_bridge
  import rvcpu_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  dm_rd_ctrl,
  input  logic [2:0]  dm_wr_ctrl,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_din,
  output logic [63:0] dm_dout,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [7:0]  bus_wstrb,
  output logic [63:0] bus_wdata,
  input  logic [63:0] bus_rdata,
  input  logic        bus_ack
);

  state_e      state_q, state_d;
  logic        wr_v, rd_v, pending, sgn;
  size_e       sz;
  logic        mis, timeout;
  logic [7:0]  al_wstrb;
  logic [63:0] al_wdata, ld_data;

  logic        bus_req_q, bus_we_q;
  logic [63:0] bus_addr_q, bus_wdata_q, dout_q;
  logic [7:0]  bus_wstrb_q;
  logic        misalign_q, bus_err_q;
  logic [2:0]  ld_off_q;
  size_e       ld_size_q;
  logic        ld_sgn_q, ld_q;

  // A valid store code overrides any simultaneous load.
  always_comb begin
    wr_v = 1'b1;
    sz   = SZ_B;
    sgn  = 1'b0;
    case (dm_wr_ctrl)
      WR_SB: sz = SZ_B;
      WR_SH: sz = SZ_H;
      WR_SW: sz = SZ_W;
      WR_SD: sz = SZ_D;
      default: wr_v = 1'b0;
    endcase
    if (!wr_v) begin
      case (dm_rd_ctrl)
        RD_LB:  begin sz = SZ_B; sgn = 1'b1; end
        RD_LBU: sz = SZ_B;
        RD_LH:  begin sz = SZ_H; sgn = 1'b1; end
        RD_LHU: sz = SZ_H;
        RD_LW:  begin sz = SZ_W; sgn = 1'b1; end
        RD_LWU: sz = SZ_W;
        RD_LD:  sz = SZ_D;
        default: ;
      endcase
    end
  end

  assign rd_v    = dm_rd_ctrl != RD_NONE;
  assign pending = wr_v | rd_v;

  dm_lane_align u_align (
    .off_i     (dm_addr[2:0]),
    .size_i    (sz),
    .din_i     (dm_din),
    .misalign_o(mis),
    .wstrb_o   (al_wstrb),
    .wdata_o   (al_wdata),
    .ld_off_i  (ld_off_q),
    .ld_size_i (ld_size_q),
    .ld_sgn_i  (ld_sgn_q),
    .rdata_i   (bus_rdata),
    .ld_data_o (ld_data)
  );

`ifdef DM_BUS_BRIDGE_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_q <= '0;
    end else if (state_q == REQ && !bus_ack) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end else begin
      to_cnt_q <= '0;
    end
  end

  assign timeout = (state_q == REQ) && !bus_ack &&
                   (to_cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_to;
  assign unused_to = ^TIMEOUT_CYCLES;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pending) state_d = mis ? DONE : REQ;
      REQ:     if (bus_ack || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
      dout_q      <= '0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      ld_off_q    <= '0;
      ld_size_q   <= SZ_B;
      ld_sgn_q    <= 1'b0;
      ld_q        <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pending && mis) begin
            misalign_q <= 1'b1;
            if (!wr_v) dout_q <= '0;
          end else if (pending) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= wr_v;
            bus_addr_q  <= {dm_addr[63:3], 3'b000};
            bus_wstrb_q <= wr_v ? al_wstrb : 8'h00;
            bus_wdata_q <= al_wdata;
            ld_off_q    <= dm_addr[2:0];
            ld_size_q   <= sz;
            ld_sgn_q    <= sgn;
            ld_q        <= !wr_v;
          end
        end
        REQ: begin
          if (bus_ack) begin
            bus_req_q <= 1'b0;
            if (ld_q) dout_q <= ld_data;
          end else if (timeout) begin
            bus_req_q <= 1'b0;
            bus_err_q <= 1'b1;
            if (ld_q) dout_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Stall is held low while reset is asserted.
  assign stall = rst & ((state_q == IDLE && pending) ||
                        state_q == REQ);

  assign dm_dout   = dout_q;
  assign misalign  = misalign_q;
  assign bus_err   = bus_err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_wdata = bus_wdata_q;

endmodule
